// File: rtl/sequenced_control_unit.sv
// sequenced_control_unit: LOAD/FETCH/DECODE/EXECUTE sequencer driving datapath enables and selects
//
// Loads LOAD_WORDS program words (one per clock with load_valid), then loops
// FETCH -> DECODE -> EXECUTE, stalling on pmem_rdy / dmem_rdy where a memory
// access is in flight.
//
// Parameters: IR_W (>=8), SR_W (>=4), ALU_MODE_W (>=4), LOAD_WORDS (>=1),
//             LA_W (2**LA_W >= LOAD_WORDS)
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   IR, SR                current instruction, status flags
//   load_valid            program word on the load bus this cycle
//   pmem_rdy, dmem_rdy    program / data memory ready
//   stage                 LOAD=00 FETCH=01 DECODE=10 EXECUTE=11
//   load_addr             program address of the current load word
//   ALU_Mode              ALU operation
//   PC_E .. MUX2_Sel      datapath enables and selects
//   halted                core halted
// Optional feature: define CU_HALT_EN to decode opcode 0000 with IR[IR_W-5:0]
// all ones as HALT; otherwise that encoding is a NOP and halted is tied to 0.
module sequenced_control_unit #(
    parameter int IR_W       = 12,
    parameter int SR_W       = 4,
    parameter int ALU_MODE_W = 4,
    parameter int LOAD_WORDS = 256,
    parameter int LA_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IR_W-1:0]       IR,
    input  logic [SR_W-1:0]       SR,
    input  logic                  load_valid,
    input  logic                  pmem_rdy,
    input  logic                  dmem_rdy,
    output logic [1:0]            stage,
    output logic [LA_W-1:0]       load_addr,
    output logic [ALU_MODE_W-1:0] ALU_Mode,
    output logic                  PC_E,
    output logic                  Acc_E,
    output logic                  SR_E,
    output logic                  IR_E,
    output logic                  DR_E,
    output logic                  PMem_E,
    output logic                  PMem_LE,
    output logic                  DMem_E,
    output logic                  DMem_WE,
    output logic                  ALU_E,
    output logic                  MUX1_Sel,
    output logic                  MUX2_Sel,
    output logic                  halted
);
    typedef enum logic [1:0] {LOAD = 2'b00, FETCH = 2'b01, DECODE = 2'b10, EXECUTE = 2'b11} stage_t;

    stage_t          state, state_nx;
    logic [LA_W-1:0] addr_nx;
    logic [3:0]      opcode;
    logic            is_imm, is_cjmp, is_mem, is_mem_wr, is_jmp, is_halt, halt_q;
    logic            unused_bits;

    assign opcode    = IR[IR_W-1:IR_W-4];
    assign is_imm    = opcode[3];
    assign is_cjmp   = opcode[3:2] == 2'b01;
    assign is_mem    = opcode[3:1] == 3'b001;
    // Memory ALU ops with IR[IR_W-4]=0 write the result back to data memory.
    assign is_mem_wr = is_mem && !IR[IR_W-4];
    assign is_jmp    = opcode == 4'b0001;
    assign stage     = state;
    assign halted    = halt_q;
    // Fields not consumed in every configuration.
    assign unused_bits = ^{IR, SR};

`ifdef CU_HALT_EN
    assign is_halt = opcode == 4'b0000 && &IR[IR_W-5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_q <= 1'b0;
        else if (state == EXECUTE && is_halt) halt_q <= 1'b1;
    end
`else
    assign is_halt = 1'b0;
    assign halt_q  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            load_addr <= '0;
        end else begin
            state     <= state_nx;
            load_addr <= addr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = load_addr;
        ALU_Mode = '0;
        PC_E     = 1'b0;
        Acc_E    = 1'b0;
        SR_E     = 1'b0;
        IR_E     = 1'b0;
        DR_E     = 1'b0;
        PMem_E   = 1'b0;
        PMem_LE  = 1'b0;
        DMem_E   = 1'b0;
        DMem_WE  = 1'b0;
        ALU_E    = 1'b0;
        MUX1_Sel = 1'b0;
        MUX2_Sel = 1'b0;
        case (state)
            LOAD: begin
                PMem_E  = load_valid;
                PMem_LE = load_valid;
                if (load_valid) begin
                    state_nx = load_addr == LA_W'(LOAD_WORDS - 1) ? FETCH : LOAD;
                    addr_nx  = load_addr == LA_W'(LOAD_WORDS - 1) ? '0 : load_addr + 1'b1;
                end
            end
            FETCH: begin
                IR_E     = 1'b1;
                PMem_E   = 1'b1;
                state_nx = pmem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                DR_E     = is_mem;
                DMem_E   = is_mem;
                state_nx = !is_mem || dmem_rdy ? EXECUTE : DECODE;
            end
            EXECUTE: begin
                // A halted core (or the HALT instruction itself) drives nothing and stays put.
                if (!halt_q && !is_halt) begin
                    state_nx = FETCH;
                    if (is_imm) begin
                        ALU_Mode = ALU_MODE_W'(IR[IR_W-2:IR_W-4]);
                        PC_E     = 1'b1;
                        Acc_E    = 1'b1;
                        SR_E     = 1'b1;
                        ALU_E    = 1'b1;
                        MUX1_Sel = 1'b1;
                        MUX2_Sel = 1'b1;
                    end else if (is_cjmp) begin
                        PC_E     = 1'b1;
                        MUX1_Sel = SR[IR[IR_W-3:IR_W-4]];
                    end else if (is_mem) begin
                        // Writes hold DMem_E/DMem_WE/ALU_E until dmem_rdy and commit PC/SR only then.
                        ALU_Mode = ALU_MODE_W'(IR[IR_W-5:IR_W-8]);
                        ALU_E    = 1'b1;
                        Acc_E    = IR[IR_W-4];
                        DMem_E   = is_mem_wr;
                        DMem_WE  = is_mem_wr;
                        PC_E     = !is_mem_wr || dmem_rdy;
                        SR_E     = !is_mem_wr || dmem_rdy;
                        state_nx = !is_mem_wr || dmem_rdy ? FETCH : EXECUTE;
                    end else begin
                        PC_E     = 1'b1;
                        MUX1_Sel = is_jmp;
                    end
                end
            end
            default: state_nx = LOAD;
        endcase
    end
endmodule
